// File: rtl/button_events.sv
// button_events: turns two debounced button levels into press/release/long/repeat pulses plus a chord pulse
module button_events #(
  parameter int HOLD_CYCLES   = 12500000,
  parameter int REPEAT_CYCLES = 2500000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       I0,
  input  logic       I1,
  output logic [1:0] press,
  output logic [1:0] rel,
  output logic [1:0] long,
  output logic [1:0] rpt,
  output logic [1:0] held,
  output logic       chord
);
  typedef enum logic [1:0] {DISARM, IDLE, PRESS, HELD} st_t;
  localparam logic [CNT_W-1:0] HT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RT = CNT_W'(REPEAT_CYCLES - 1);
  st_t             st  [2];
  logic [CNT_W-1:0] cnt [2];
  logic [1:0]      in;
  logic [1:0]      hn;
  logic            armed;
  assign in = {I1, I0};
  // next-cycle held level: any armed state with the button down ends up in PRESS or HELD
  always_comb begin
    hn = '0;
    for (int n = 0; n < 2; n++) hn[n] = in[n] && st[n] != DISARM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      press <= '0;
      rel   <= '0;
      long  <= '0;
      rpt   <= '0;
      held  <= '0;
      chord <= 1'b0;
      armed <= 1'b1;
      for (int n = 0; n < 2; n++) begin
        st[n]  <= DISARM;
        cnt[n] <= '0;
      end
    end else begin
      press <= '0;
      rel   <= '0;
      long  <= '0;
      rpt   <= '0;
      held  <= hn;
      chord <= armed && &hn;
      armed <= armed ? ~&hn : ~|hn;
      for (int n = 0; n < 2; n++) begin
        case (st[n])
          DISARM: if (!in[n]) st[n] <= IDLE;
          IDLE: if (in[n]) begin
            st[n]    <= PRESS;
            press[n] <= 1'b1;
            cnt[n]   <= '0;
          end
          PRESS: if (!in[n]) begin
            st[n]  <= IDLE;
            rel[n] <= 1'b1;
            cnt[n] <= '0;
          end else if (cnt[n] == HT) begin
            st[n]   <= HELD;
            long[n] <= 1'b1;
            cnt[n]  <= '0;
          end else cnt[n] <= cnt[n] + 1'b1;
          HELD: if (!in[n]) begin
            st[n]  <= IDLE;
            rel[n] <= 1'b1;
            cnt[n] <= '0;
          end else if (!REPEAT_EN) cnt[n] <= '0;
          else if (cnt[n] == RT) begin
            rpt[n] <= 1'b1;
            cnt[n] <= '0;
          end else cnt[n] <= cnt[n] + 1'b1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed vectors with a per-cycle expected-output scoreboard
module tb_button_events;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic I0 = 1'b1;
  logic I1 = 1'b0;
  logic [1:0] press, rel, long, rpt, held;
  logic chord;
  logic [10:0] q[$];
  int total = 0;
  int bad = 0;

  button_events #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(1'b1), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .I0(I0), .I1(I1),
    .press(press), .rel(rel), .long(long), .rpt(rpt), .held(held), .chord(chord)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] ev(input int p, input int rl, input int lg, input int rp, input int hd, input int c);
    return {p[1:0], rl[1:0], lg[1:0], rp[1:0], hd[1:0], c[0]};
  endfunction

  task automatic drv(input int a, input int b, input int r, input logic [10:0] e, input int n);
    repeat (n) begin
      @(negedge clk);
      I0 = a[0];
      I1 = b[0];
      rst = r[0];
      q.push_back(e);
    end
  endtask

  // monitor: every cycle with a pending expectation is compared {press,rel,long,rpt,held,chord}
  always @(posedge clk) begin
    logic [10:0] got, exp;
    #1;
    if (q.size() != 0) begin
      exp = q.pop_front();
      got = {press, rel, long, rpt, held, chord};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL outputs cmp#%0d t=%0t got p=%b r=%b l=%b t=%b h=%b c=%b want p=%b r=%b l=%b t=%b h=%b c=%b",
                 total, $time, got[10:9], got[8:7], got[6:5], got[4:3], got[2:1], got[0],
                 exp[10:9], exp[8:7], exp[6:5], exp[4:3], exp[2:1], exp[0]);
      end
    end
  end

  initial begin
    logic [10:0] z, p0, h0, p1, h1;
    z  = '0;
    p0 = ev(1, 0, 0, 0, 1, 0);
    h0 = ev(0, 0, 0, 0, 1, 0);
    p1 = ev(2, 0, 0, 0, 2, 0);
    h1 = ev(0, 0, 0, 0, 2, 0);
    // button down through reset and beyond: silent until it is released once
    drv(1, 0, 1, z, 2);
    drv(1, 0, 0, z, 20);
    drv(0, 0, 0, z, 1);
    drv(1, 0, 0, p0, 1);
    drv(0, 0, 0, ev(0, 1, 0, 0, 0, 0), 1);
    drv(0, 0, 0, z, 2);
    // short 3-cycle press
    drv(1, 0, 0, p0, 1);
    drv(1, 0, 0, h0, 2);
    drv(0, 0, 0, ev(0, 1, 0, 0, 0, 0), 1);
    drv(0, 0, 0, z, 2);
    // long hold with repeats; release lands on a repeat terminal count
    drv(1, 0, 0, p0, 1);
    drv(1, 0, 0, h0, 7);
    drv(1, 0, 0, ev(0, 0, 1, 0, 1, 0), 1);
    drv(1, 0, 0, h0, 3);
    drv(1, 0, 0, ev(0, 0, 0, 1, 1, 0), 1);
    drv(1, 0, 0, h0, 3);
    drv(1, 0, 0, ev(0, 0, 0, 1, 1, 0), 1);
    drv(1, 0, 0, h0, 3);
    drv(1, 0, 0, ev(0, 0, 0, 1, 1, 0), 1);
    drv(1, 0, 0, h0, 3);
    drv(0, 0, 0, ev(0, 1, 0, 0, 0, 0), 1);
    drv(0, 0, 0, z, 2);
    // release on the hold terminal count
    drv(1, 0, 0, p0, 1);
    drv(1, 0, 0, h0, 7);
    drv(0, 0, 0, ev(0, 1, 0, 0, 0, 0), 1);
    drv(0, 0, 0, z, 2);
    // chord: staggered, re-press without re-arm, then simultaneous
    drv(1, 0, 0, p0, 1);
    drv(1, 0, 0, h0, 4);
    drv(1, 1, 0, ev(2, 0, 0, 0, 3, 1), 1);
    drv(1, 1, 0, ev(0, 0, 0, 0, 3, 0), 1);
    drv(1, 0, 0, ev(0, 2, 0, 0, 1, 0), 1);
    drv(1, 1, 0, ev(2, 0, 1, 0, 3, 0), 1);
    drv(0, 0, 0, ev(0, 3, 0, 0, 0, 0), 1);
    drv(0, 0, 0, z, 1);
    drv(1, 1, 0, ev(3, 0, 0, 0, 3, 1), 1);
    drv(0, 0, 0, ev(0, 3, 0, 0, 0, 0), 1);
    drv(0, 0, 0, z, 2);
    // reset mid-hold on button 1: no release, silent until released and re-pressed
    drv(0, 1, 0, p1, 1);
    drv(0, 1, 0, h1, 7);
    drv(0, 1, 0, ev(0, 0, 2, 0, 2, 0), 1);
    drv(0, 1, 0, h1, 3);
    drv(0, 1, 1, z, 1);
    drv(0, 1, 0, z, 4);
    drv(0, 0, 0, z, 1);
    drv(0, 1, 0, p1, 1);
    drv(0, 0, 0, ev(0, 2, 0, 0, 0, 0), 1);
    drv(0, 0, 0, z, 2);
    repeat (10) begin
      if (q.size() != 0) @(negedge clk);
    end
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
